// File: rtl/row_window_gen.sv
// row_window_gen: turns a stream of packed row-buffer columns into K parallel
// KxK convolution windows (one per output row) at every stride-aligned column.
// Optional build macro: ROW_WINDOW_ZERO_PAD_EN enables horizontal "same" padding,
// which adds a DRAIN state that shifts in P zero columns after each row.
module row_window_gen #(
   parameter int unsigned K      = 3,
   parameter int unsigned STRIDE = 1,
   parameter int unsigned IMG_W  = 256,
   parameter int unsigned DATA_W = 8,
   localparam int unsigned R     = STRIDE * K - STRIDE + K,
   localparam int unsigned P     = (K - 1) / 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [R*DATA_W-1:0]      col_in,
   output logic                     out_valid,
   output logic [K*K*K*DATA_W-1:0]  win_out,
   output logic [$clog2(IMG_W)-1:0] out_col,
   output logic                     row_done,
   output logic                     err
);

`ifdef ROW_WINDOW_ZERO_PAD_EN
   localparam bit PadEn = 1'b1;
`else
   localparam bit PadEn = 1'b0;
`endif
   localparam int unsigned PAD       = PadEn ? P : 0;
   // Counter works on the virtual (padded) column index.
   localparam int unsigned VW        = IMG_W + 2 * PAD;
   localparam int unsigned NWIN      = (VW - K) / STRIDE + 1;
   localparam int unsigned LAST_EMIT = K - 1 + (NWIN - 1) * STRIDE;
   localparam int unsigned LAST_REAL = IMG_W - 1 + PAD;
   localparam int unsigned CW        = $clog2(VW + 1);
   localparam int unsigned PW        = (STRIDE > 1) ? $clog2(STRIDE) : 1;
   localparam int unsigned OW        = $clog2(IMG_W);
   localparam int unsigned CWORD     = R * DATA_W;

`ifdef ROW_WINDOW_ZERO_PAD_EN
   localparam int unsigned LAST_VIRT = VW - 1;
   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;
`else
   typedef enum logic [1:0] {StIdle, StRun} state_e;
`endif

   state_e                  state_q, state_d;
   logic [CWORD-1:0]        hist_q [K-1];   // hist_q[0] is the oldest column
   logic [CWORD-1:0]        cols [K];
   logic [CWORD-1:0]        new_col;
   logic [CW-1:0]           c_q;
   logic [PW-1:0]           phase_q;
   logic [OW-1:0]           ocnt_q;
   logic                    shift, emit, last_win, row_end;
   logic [K*K*K*DATA_W-1:0] win_d;

   // Next state plus per-cycle control: column accept, emission, end of row.
   always_comb begin
      state_d = state_q;
      shift   = 1'b0;
      new_col = col_in;
      row_end = 1'b0;
      case (state_q)
         StIdle, StRun: begin
            if (in_valid) begin
               shift   = 1'b1;
               state_d = StRun;
               if (c_q == CW'(LAST_REAL)) begin
`ifdef ROW_WINDOW_ZERO_PAD_EN
                  state_d = StDrain;
`else
                  state_d = StIdle;
                  row_end = 1'b1;
`endif
               end
            end
         end
`ifdef ROW_WINDOW_ZERO_PAD_EN
         StDrain: begin
            // Incoming data is ignored here; a zero column is shifted instead.
            shift   = 1'b1;
            new_col = '0;
            if (c_q == CW'(LAST_VIRT)) begin
               state_d = StIdle;
               row_end = 1'b1;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
      emit     = shift && (c_q >= CW'(K - 1)) && (phase_q == '0);
      last_win = emit && (c_q == CW'(LAST_EMIT));
   end

   // Window assembly: stored columns plus the incoming column at position K-1.
   always_comb begin
      for (int unsigned i = 0; i < K - 1; i++) cols[i] = hist_q[i];
      cols[K-1] = new_col;
      win_d = '0;
      for (int unsigned j = 0; j < K; j++) begin
         for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
               win_d[((j * K + r) * K + c) * DATA_W +: DATA_W] =
                  cols[c][(j * STRIDE + r) * DATA_W +: DATA_W];
            end
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Column history, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < K - 1; i++) hist_q[i] <= '0;
         c_q       <= CW'(PAD);
         phase_q   <= '0;
         ocnt_q    <= '0;
         out_valid <= 1'b0;
         win_out   <= '0;
         out_col   <= '0;
         row_done  <= 1'b0;
      end else begin
         out_valid <= emit;
         row_done  <= last_win;
         if (emit) begin
            win_out <= win_d;
            out_col <= ocnt_q;
         end
         if (row_end) begin
            // Clearing history keeps windows from spanning two rows.
            for (int unsigned i = 0; i < K - 1; i++) hist_q[i] <= '0;
            c_q     <= CW'(PAD);
            phase_q <= '0;
            ocnt_q  <= '0;
         end else if (shift) begin
            for (int unsigned i = 0; i < K - 2; i++) hist_q[i] <= hist_q[i + 1];
            hist_q[K-2] <= new_col;
            c_q         <= c_q + CW'(1);
            if (c_q >= CW'(K - 1)) begin
               phase_q <= (phase_q == PW'(STRIDE - 1)) ? '0 : phase_q + PW'(1);
            end
            if (emit) ocnt_q <= ocnt_q + OW'(1);
         end
      end
   end

`ifdef ROW_WINDOW_ZERO_PAD_EN
   // Sticky: a column offered while draining is dropped and flagged.
   always_ff @(posedge clk) begin
      if (!rst_n)                               err <= 1'b0;
      else if ((state_q == StDrain) && in_valid) err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_row_window_gen.sv
// Testbench for row_window_gen: two instances (stride 1 / width 8 and
// stride 2 / width 9), table-driven rows checked through a scoreboard.
module tb_row_window_gen;

   localparam int K    = 3;
   localparam int DW   = 8;
   localparam int SA   = 1;
   localparam int WA   = 8;
   localparam int SB   = 2;
   localparam int WB   = 9;
   localparam int RA   = SA * K - SA + K;
   localparam int RB   = SB * K - SB + K;
   localparam int WINW = K * K * K * DW;
`ifdef ROW_WINDOW_ZERO_PAD_EN
   localparam int PAD  = (K - 1) / 2;
`else
   localparam int PAD  = 0;
`endif
   localparam int NWA  = (WA + 2 * PAD - K) / SA + 1;
   localparam int NWB  = (WB + 2 * PAD - K) / SB + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic iv_a = 1'b0, iv_b = 1'b0;
   logic [RA*DW-1:0] col_a = '0;
   logic [RB*DW-1:0] col_b = '0;
   logic ov_a, ov_b, rd_a, rd_b, err_a, err_b;
   logic [WINW-1:0] win_a, win_b;
   logic [$clog2(WA)-1:0] oc_a;
   logic [$clog2(WB)-1:0] oc_b;

   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;
   int wcnt [2];

   typedef struct {
      logic [WINW-1:0] win;
      int              col;
      logic            done;
      int              cyc;
   } exp_t;
   exp_t qa[$];
   exp_t qb[$];

   typedef struct {
      int sel;
      int off;
      int gap_at;
      int gap_len;
      int nwin;
   } vec_t;
   vec_t vt [5];

   row_window_gen #(.K(K), .STRIDE(SA), .IMG_W(WA), .DATA_W(DW)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .col_in(col_a), .out_valid(ov_a),
      .win_out(win_a), .out_col(oc_a), .row_done(rd_a), .err(err_a)
   );

   row_window_gen #(.K(K), .STRIDE(SB), .IMG_W(WB), .DATA_W(DW)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .col_in(col_b), .out_valid(ov_b),
      .win_out(win_b), .out_col(oc_b), .row_done(rd_b), .err(err_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Pixel of row i, real column x; outside the image it is padding zero.
   function automatic logic [7:0] pix(input int row, input int x, input int off, input int w);
      if (x < 0 || x >= w) return 8'h00;
      return 8'((16 * row + x + off) & 255);
   endfunction

   // Expected windows for the emission at virtual column v.
   function automatic logic [WINW-1:0] exp_win(input int s, input int w, input int v,
                                               input int off);
      logic [WINW-1:0] e;
      e = '0;
      for (int j = 0; j < K; j++)
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
               e[((j * K + r) * K + c) * DW +: DW] = pix(j * s + r, v - (K - 1) + c - PAD, off, w);
      return e;
   endfunction

   task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push_exp(input int sel, input int v, input int off, input int at);
      int s;
      int w;
      int nwin;
      exp_t e;
      s = sel ? SB : SA;
      w = sel ? WB : WA;
      nwin = (w + 2 * PAD - K) / s + 1;
      if (v < K - 1 || ((v - (K - 1)) % s) != 0) return;
      e.win  = exp_win(s, w, v, off);
      e.col  = (v - (K - 1)) / s;
      e.done = (e.col == nwin - 1);
      e.cyc  = at;
      if (sel != 0) qb.push_back(e);
      else          qa.push_back(e);
   endtask

   task automatic send_col(input int sel, input int x, input int off);
      int w;
      w = sel ? WB : WA;
      @(negedge clk);
      if (sel != 0) begin
         iv_b = 1'b1;
         for (int i = 0; i < RB; i++) col_b[i*DW +: DW] = pix(i, x, off, w);
      end else begin
         iv_a = 1'b1;
         for (int i = 0; i < RA; i++) col_a[i*DW +: DW] = pix(i, x, off, w);
      end
      push_exp(sel, x + PAD, off, cyc + 1);
      if (x == w - 1)
         for (int d = 1; d <= PAD; d++) push_exp(sel, x + PAD + d, off, cyc + 1 + d);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         iv_a = 1'b0;
         iv_b = 1'b0;
      end
   endtask

   task automatic send_row(input int sel, input int off, input int gap_at, input int gap_len,
                           input int tail);
      int w;
      w = sel ? WB : WA;
      for (int x = 0; x < w; x++) begin
         send_col(sel, x, off);
         if (x == gap_at) idle(gap_len);
      end
      idle(tail);
   endtask

   task automatic check_out(input int sel, input logic [WINW-1:0] win, input int col,
                            input logic done);
      exp_t e;
      wcnt[sel]++;
      if ((sel != 0 && qb.size() == 0) || (sel == 0 && qa.size() == 0)) begin
         n_vec++;
         n_err++;
         $display("FAIL dut%0d_unexpected: got out_valid at cycle %0d, required none", sel, cyc);
         return;
      end
      if (sel != 0) e = qb.pop_front();
      else          e = qa.pop_front();
      cmp($sformatf("dut%0d_cycle", sel), 256'(cyc), 256'(e.cyc));
      cmp($sformatf("dut%0d_win col%0d", sel, e.col), 256'(win), 256'(e.win));
      cmp($sformatf("dut%0d_out_col", sel), 256'(col), 256'(e.col));
      cmp($sformatf("dut%0d_row_done col%0d", sel, e.col), 256'(done), 256'(e.done));
   endtask

   // Output monitor: every out_valid must match the head of the scoreboard.
   always @(negedge clk) begin
      if (ov_a) check_out(0, win_a, int'(oc_a), rd_a);
      if (ov_b) check_out(1, win_b, int'(oc_b), rd_b);
   end

   initial begin
      vt[0] = '{sel: 0, off: 0,  gap_at: -1, gap_len: 0, nwin: NWA};
      vt[1] = '{sel: 1, off: 0,  gap_at: -1, gap_len: 0, nwin: NWB};
      vt[2] = '{sel: 0, off: 0,  gap_at: 4,  gap_len: 3, nwin: NWA};
      vt[3] = '{sel: 1, off: 50, gap_at: 3,  gap_len: 2, nwin: NWB};
      vt[4] = '{sel: 0, off: 37, gap_at: 0,  gap_len: 1, nwin: NWA};

      // Reset state.
      repeat (2) @(negedge clk);
      cmp("rst_out_valid_a", 256'(ov_a), 256'(0));
      cmp("rst_win_a", 256'(win_a), 256'(0));
      cmp("rst_out_col_a", 256'(oc_a), 256'(0));
      cmp("rst_row_done_a", 256'(rd_a), 256'(0));
      cmp("rst_err_a", 256'(err_a), 256'(0));
      cmp("rst_out_valid_b", 256'(ov_b), 256'(0));
      cmp("rst_win_b", 256'(win_b), 256'(0));
      cmp("rst_err_b", 256'(err_b), 256'(0));
      rst_n = 1'b1;
      idle(2);

      // Table-driven rows: contiguous, gapped, both strides.
      for (int i = 0; i < 5; i++) begin
         wcnt[vt[i].sel] = 0;
         send_row(vt[i].sel, vt[i].off, vt[i].gap_at, vt[i].gap_len, 3 + PAD);
         cmp($sformatf("vec%0d_window_count", i), 256'(wcnt[vt[i].sel]), 256'(vt[i].nwin));
         cmp($sformatf("vec%0d_scoreboard_empty", i), 256'(qa.size() + qb.size()), 256'(0));
      end

      // Back-to-back rows; second row carries +100 data.
      wcnt[0] = 0;
      send_row(0, 0, -1, 0, PAD);
      send_row(0, 100, -1, 0, 3 + PAD);
      cmp("b2b_window_count", 256'(wcnt[0]), 256'(2 * NWA));
      cmp("b2b_scoreboard_empty", 256'(qa.size()), 256'(0));

      // Reset after column 3, then a clean row.
      for (int x = 0; x < 4; x++) send_col(0, x, 0);
      @(negedge clk);
      rst_n = 1'b0;
      iv_a  = 1'b0;
      @(negedge clk);
      cmp("midrst_out_valid", 256'(ov_a), 256'(0));
      cmp("midrst_win", 256'(win_a), 256'(0));
      cmp("midrst_out_col", 256'(oc_a), 256'(0));
      cmp("midrst_row_done", 256'(rd_a), 256'(0));
      cmp("midrst_scoreboard_empty", 256'(qa.size()), 256'(0));
      rst_n = 1'b1;
      wcnt[0] = 0;
      send_row(0, 20, -1, 0, 3 + PAD);
      cmp("postrst_window_count", 256'(wcnt[0]), 256'(NWA));
      cmp("postrst_scoreboard_empty", 256'(qa.size()), 256'(0));

`ifdef ROW_WINDOW_ZERO_PAD_EN
      // Column offered during DRAIN: ignored, sets sticky err.
      send_row(0, 0, -1, 0, 0);
      @(negedge clk);
      iv_a = 1'b1;
      idle(3);
      cmp("drain_err_set", 256'(err_a), 256'(1));
      idle(2);
      cmp("drain_err_sticky", 256'(err_a), 256'(1));
      cmp("drain_scoreboard_empty", 256'(qa.size()), 256'(0));
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cmp("drain_err_cleared", 256'(err_a), 256'(0));
`else
      cmp("err_a_tied_low", 256'(err_a), 256'(0));
      cmp("err_b_tied_low", 256'(err_b), 256'(0));
`endif
      cmp("dut_b_scoreboard_empty", 256'(qb.size()), 256'(0));

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
